// File: rtl/pkt_gen_pkg.sv
// Shared types and constants for the packet generator.
//   mode_e    : error-injection selection carried with each packet
//   state_e   : framing FSM states (header, payload, checksum)
//   lfsr_taps : Galois feedback mask for each supported beat width
package pkt_gen_pkg;

  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    GOOD     = 2'd0,
    BAD_CSUM = 2'd1,
    BAD_LEN  = 2'd2,
    RSVD     = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    PAY  = 2'd2,
    CSUM = 2'd3
  } state_e;

  // Right-shifting Galois masks for maximal-length sequences.
  // The 8-bit mask matches x^8+x^6+x^5+x^4+1.
  function automatic logic [31:0] lfsr_taps(input int unsigned width);
    logic [31:0] taps;
    case (width)
      8:       taps = 32'h0000_00B8;
      16:      taps = 32'h0000_B400;
      32:      taps = 32'h8020_0003;
      default: taps = 32'h0000_00B8;
    endcase
    return taps;
  endfunction

endpackage

// File: rtl/pkt_gen_err_inject_lfsr.sv
// Galois LFSR that supplies the packet payload words.
//   clk, rst     : clock, synchronous active-high reset (state <- SEED)
//   load         : load load_val; a zero load_val is replaced by SEED
//   load_val     : value to load
//   step         : advance the sequence by one position (load has priority)
//   state        : current LFSR value
//   state_next_c : value the register takes at the next edge (combinational)
module pkt_lfsr
  import pkt_gen_pkg::*;
#(
  parameter int unsigned        DATA_W = 8,
  parameter logic [DATA_W-1:0]  SEED   = DATA_W'('hA5)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_val,
  input  logic              step,
  output logic [DATA_W-1:0] state,
  output logic [DATA_W-1:0] state_next_c
);

  localparam logic [DATA_W-1:0] TAPS = DATA_W'(lfsr_taps(DATA_W));

  logic [DATA_W-1:0] state_q;

  // Next value: a zero seed would lock the register, so it is swapped for SEED.
  always_comb begin
    state_next_c = state_q;
    if (load) begin
      state_next_c = (load_val == '0) ? SEED : load_val;
    end else if (step) begin
      state_next_c = {1'b0, state_q[DATA_W-1:1]} ^ (state_q[0] ? TAPS : '0);
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SEED;
    end else begin
      state_q <= state_next_c;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/pkt_gen_err_inject.sv
// Framed packet generator with selectable error injection.
// A packet is one header beat (payload length), L LFSR payload beats and
// one XOR checksum beat, presented on a valid/ready stream.
//   clk, rst            : clock, synchronous active-high reset
//   start, len, mode    : packet request (sampled in IDLE only)
//   seed_load, seed     : LFSR reseed (honoured in IDLE only)
//   out_data/valid/ready/sop/eop : output beat stream
//   busy                : packet in flight
//   pkt_cnt, err_cnt    : saturating completed / corrupted packet counts
module pkt_gen_err_inject
  import pkt_gen_pkg::*;
#(
  parameter int unsigned       DATA_W    = 8,
  parameter int unsigned       MAX_LEN   = 16,
  parameter int unsigned       LEN_W     = $clog2(MAX_LEN + 1),
  parameter logic [DATA_W-1:0] LFSR_SEED = DATA_W'('hA5)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic [1:0]        mode,
  input  logic              seed_load,
  input  logic [DATA_W-1:0] seed,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sop,
  output logic              out_eop,
  output logic              busy,
  output logic [CNT_W-1:0]  pkt_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  state_e            state_q, state_d;
  mode_e             mode_q, mode_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [DATA_W-1:0] csum_q, csum_d;

  logic [DATA_W-1:0] out_data_d;
  logic              out_valid_d;
  logic              out_sop_d;
  logic              out_eop_d;
  logic              busy_d;
  logic [CNT_W-1:0]  pkt_cnt_d;
  logic [CNT_W-1:0]  err_cnt_d;

  logic              accept_c;
  mode_e             mode_in_c;
  logic [LEN_W-1:0]  len_eff_c;
  logic [DATA_W-1:0] hdr_c;
  logic [DATA_W-1:0] pay_xor_c;
  logic              lfsr_load_c;
  logic              lfsr_step_c;
  logic [DATA_W-1:0] lfsr_state;
  logic [DATA_W-1:0] lfsr_next_c;

  assign accept_c  = out_valid & out_ready;
  assign mode_in_c = mode_e'(mode);
  assign len_eff_c = (len > MAX_LEN_L) ? MAX_LEN_L : len;

  // Header carries the clamped length; BAD_LEN overstates it by one.
  assign hdr_c = DATA_W'(len_eff_c) +
                 {{(DATA_W-1){1'b0}}, (mode_in_c == BAD_LEN)};

  // Running checksum including the payload beat currently on the bus.
  assign pay_xor_c = csum_q ^ out_data;

  assign lfsr_load_c = (state_q == IDLE) & seed_load;
  assign lfsr_step_c = (state_q == PAY) & accept_c;

  pkt_lfsr #(
    .DATA_W (DATA_W),
    .SEED   (LFSR_SEED)
  ) u_lfsr (
    .clk          (clk),
    .rst          (rst),
    .load         (lfsr_load_c),
    .load_val     (seed),
    .step         (lfsr_step_c),
    .state        (lfsr_state),
    .state_next_c (lfsr_next_c)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    rem_d       = rem_q;
    csum_d      = csum_q;
    out_data_d  = out_data;
    out_valid_d = out_valid;
    out_sop_d   = out_sop;
    out_eop_d   = out_eop;
    pkt_cnt_d   = pkt_cnt;
    err_cnt_d   = err_cnt;

    case (state_q)
      IDLE: begin
        if (start && (len != '0)) begin
          state_d     = HDR;
          mode_d      = mode_in_c;
          rem_d       = len_eff_c;
          csum_d      = hdr_c;
          out_data_d  = hdr_c;
          out_valid_d = 1'b1;
          out_sop_d   = 1'b1;
          out_eop_d   = 1'b0;
        end
      end

      HDR: begin
        // LFSR does not step on the header, so its current value is payload beat 0.
        if (accept_c) begin
          state_d    = PAY;
          out_sop_d  = 1'b0;
          out_data_d = lfsr_state;
        end
      end

      PAY: begin
        if (accept_c) begin
          csum_d = pay_xor_c;
          if (rem_q == LEN_W'(1)) begin
            state_d    = CSUM;
            out_eop_d  = 1'b1;
            out_data_d = pay_xor_c ^
                         {{(DATA_W-1){1'b0}}, (mode_q == BAD_CSUM)};
          end else begin
            rem_d      = rem_q - LEN_W'(1);
            out_data_d = lfsr_next_c;
          end
        end
      end

      CSUM: begin
        if (accept_c) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          out_eop_d   = 1'b0;
          out_data_d  = '0;
          if (pkt_cnt != '1) begin
            pkt_cnt_d = pkt_cnt + CNT_W'(1);
          end
          if (((mode_q == BAD_CSUM) || (mode_q == BAD_LEN)) && (err_cnt != '1)) begin
            err_cnt_d = err_cnt + CNT_W'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mode_q    <= GOOD;
      rem_q     <= '0;
      csum_q    <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      busy      <= 1'b0;
      pkt_cnt   <= '0;
      err_cnt   <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      rem_q     <= rem_d;
      csum_q    <= csum_d;
      out_data  <= out_data_d;
      out_valid <= out_valid_d;
      out_sop   <= out_sop_d;
      out_eop   <= out_eop_d;
      busy      <= busy_d;
      pkt_cnt   <= pkt_cnt_d;
      err_cnt   <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_pkt_gen_err_inject.sv
// Directed bench for pkt_gen_err_inject (DATA_W=8, MAX_LEN=16, seed 'hA5).
// Expected payload sequence from seed A5 with mask B8:
//   A5 EA 75 82 41 98 4C 26 13 B1 E0 70 38 1C 0E 07
module tb_pkt_gen_err_inject;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned MAX_LEN = 16;
  localparam int unsigned LEN_W   = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [LEN_W-1:0]  len;
  logic [1:0]        mode;
  logic              seed_load;
  logic [DATA_W-1:0] seed;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_sop;
  logic              out_eop;
  logic              busy;
  logic [15:0]       pkt_cnt;
  logic [15:0]       err_cnt;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_d[$];
  logic       got_sop[$];
  logic       got_eop[$];

  always #5 clk = ~clk;

  pkt_gen_err_inject #(
    .DATA_W    (DATA_W),
    .MAX_LEN   (MAX_LEN),
    .LEN_W     (LEN_W),
    .LFSR_SEED (8'hA5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .mode      (mode),
    .seed_load (seed_load),
    .seed      (seed),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sop   (out_sop),
    .out_eop   (out_eop),
    .busy      (busy),
    .pkt_cnt   (pkt_cnt),
    .err_cnt   (err_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Request one packet and collect its beats; optionally stall before beat
  // stall_beat for stall_cyc cycles and hold start high for the whole packet.
  task automatic send_pkt(input string tag, input logic [1:0] m, input int l,
                          input logic ld, input logic [7:0] sd,
                          input int stall_beat, input int stall_cyc,
                          input logic hold_start);
    int   stalls;
    int   guard;
    logic done;
    logic [7:0] held;
    stalls = 0;
    guard  = 0;
    done   = 1'b0;
    held   = '0;
    got_d.delete();
    got_sop.delete();
    got_eop.delete();
    start     = 1'b1;
    len       = LEN_W'(l);
    mode      = m;
    seed_load = ld;
    seed      = sd;
    step();
    if (!hold_start) start = 1'b0;
    seed_load = 1'b0;
    while (!done && guard < 100) begin
      guard++;
      if (got_d.size() == stall_beat && stalls < stall_cyc) begin
        out_ready = 1'b0;
        if (stalls > 0) begin
          chk({tag, "_hold_data"}, 32'(out_data), 32'(held));
          chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
        end
        held = out_data;
        stalls++;
      end else begin
        out_ready = 1'b1;
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        if (out_valid) begin
          got_d.push_back(out_data);
          got_sop.push_back(out_sop);
          got_eop.push_back(out_eop);
          if (out_eop) done = 1'b1;
        end
      end
      step();
    end
    start = 1'b0;
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic check_pkt(input string tag);
    chk({tag, "_nbeats"}, 32'(got_d.size()), 32'(exp_q.size()));
    for (int i = 0; i < got_d.size() && i < exp_q.size(); i++) begin
      chk($sformatf("%s_b%0d", tag, i), 32'(got_d[i]), 32'(exp_q[i]));
      chk($sformatf("%s_sop%0d", tag, i), 32'(got_sop[i]), 32'(i == 0));
      chk($sformatf("%s_eop%0d", tag, i), 32'(got_eop[i]), 32'(i == exp_q.size() - 1));
    end
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    len       = '0;
    mode      = 2'd0;
    seed_load = 1'b0;
    seed      = '0;
    out_ready = 1'b1;
    repeat (2) step();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_sop", 32'(out_sop), 32'd0);
    chk("rst_pkt", 32'(pkt_cnt), 32'd0);
    chk("rst_err", 32'(err_cnt), 32'd0);
    rst = 1'b0;

    // Good packet from the reset seed.
    exp_q = '{8'h03, 8'hA5, 8'hEA, 8'h75, 8'h39};
    send_pkt("t1", 2'd0, 3, 1'b0, 8'h00, -1, 0, 1'b0);
    check_pkt("t1");
    chk("t1_pkt", 32'(pkt_cnt), 32'd1);
    chk("t1_err", 32'(err_cnt), 32'd0);

    // Bad checksum: good XOR 39 flipped in bit 0.
    exp_q = '{8'h03, 8'hA5, 8'hEA, 8'h75, 8'h38};
    send_pkt("t2", 2'd1, 3, 1'b1, 8'hA5, -1, 0, 1'b0);
    check_pkt("t2");
    chk("t2_pkt", 32'(pkt_cnt), 32'd2);
    chk("t2_err", 32'(err_cnt), 32'd1);

    // Bad length: header says 4 while three payload beats follow.
    exp_q = '{8'h04, 8'hA5, 8'hEA, 8'h75, 8'h3E};
    send_pkt("t3", 2'd2, 3, 1'b1, 8'hA5, -1, 0, 1'b0);
    check_pkt("t3");
    chk("t3_len_mismatch", 32'(int'(got_d[0]) != got_d.size() - 2), 32'd1);
    chk("t3_pkt", 32'(pkt_cnt), 32'd3);
    chk("t3_err", 32'(err_cnt), 32'd2);

    // Back-pressure on payload beat 2 with start held high throughout.
    exp_q = '{8'h03, 8'hA5, 8'hEA, 8'h75, 8'h39};
    send_pkt("t4", 2'd0, 3, 1'b1, 8'hA5, 2, 3, 1'b1);
    check_pkt("t4");
    repeat (2) begin
      step();
      chk("t4_no_restart", 32'(out_valid), 32'd0);
    end
    chk("t4_pkt", 32'(pkt_cnt), 32'd4);
    chk("t4_err", 32'(err_cnt), 32'd2);

    // Zero length request is dropped.
    start = 1'b1;
    len   = '0;
    mode  = 2'd0;
    step();
    start = 1'b0;
    repeat (3) begin
      chk("t5_len0_valid", 32'(out_valid), 32'd0);
      chk("t5_len0_busy", 32'(busy), 32'd0);
      step();
    end

    // Over-length request clamps to 16; zero seed falls back to A5.
    exp_q = '{8'h10, 8'hA5, 8'hEA, 8'h75, 8'h82, 8'h41, 8'h98, 8'h4C, 8'h26,
              8'h13, 8'hB1, 8'hE0, 8'h70, 8'h38, 8'h1C, 8'h0E, 8'h07, 8'h04};
    send_pkt("t5", 2'd0, 20, 1'b1, 8'h00, -1, 0, 1'b0);
    check_pkt("t5");
    chk("t5_pkt", 32'(pkt_cnt), 32'd5);

    // Reset while payload beat 2 is on the bus.
    start     = 1'b1;
    len       = LEN_W'(3);
    mode      = 2'd0;
    seed_load = 1'b1;
    seed      = 8'hA5;
    out_ready = 1'b1;
    step();
    start     = 1'b0;
    seed_load = 1'b0;
    step();
    step();
    chk("t6_pre_data", 32'(out_data), 32'hEA);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_valid", 32'(out_valid), 32'd0);
    chk("t6_eop", 32'(out_eop), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_pkt", 32'(pkt_cnt), 32'd0);
    chk("t6_err", 32'(err_cnt), 32'd0);
    exp_q = '{8'h03, 8'hA5, 8'hEA, 8'h75, 8'h39};
    send_pkt("t6b", 2'd0, 3, 1'b0, 8'h00, -1, 0, 1'b0);
    check_pkt("t6b");
    chk("t6b_pkt", 32'(pkt_cnt), 32'd1);

    // Reserved mode behaves as good; single payload beat.
    exp_q = '{8'h01, 8'hA5, 8'hA4};
    send_pkt("t7", 2'd3, 1, 1'b1, 8'hA5, -1, 0, 1'b0);
    check_pkt("t7");
    chk("t7_pkt", 32'(pkt_cnt), 32'd2);
    chk("t7_err", 32'(err_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
